// File: rtl/my_ycbcr.sv
`default_nettype none
// ============================================================================
// Module   : my_ycbcr
// Purpose  : Three-stage AXI4-Stream RGB888 -> YCbCr 4:4:4 converter
//            (BT.601 full range, 8-bit coefficients), with back-pressure.
// Revision : 1.0  initial release
// ============================================================================
module my_ycbcr (
   input  logic        clk,
   input  logic        rstn,
   input  logic [23:0] s_axis_video_tdata,
   input  logic        s_axis_video_tvalid,
   output logic        s_axis_video_tready,
   input  logic        s_axis_video_tuser,
   input  logic        s_axis_video_tlast,
   output logic [23:0] m_axis_video_tdata,
   output logic        m_axis_video_tvalid,
   input  logic        m_axis_video_tready,
   output logic        m_axis_video_tuser,
   output logic        m_axis_video_tlast
);

   // Coefficient order: Y(R,G,B), Cb(R,G,B), Cr(R,G,B); signs are applied in S2
   localparam logic [8:0][7:0] c_coef = {8'd21, 8'd107, 8'd128,
                                         8'd128, 8'd85, 8'd43,
                                         8'd29, 8'd150, 8'd77};
   localparam logic signed [17:0] c_rnd = 18'sd128;
   localparam logic signed [10:0] c_ofs = 11'sd128;

   logic             w_en;
   logic [2:0][7:0]  w_chan;
   logic [8:0][15:0] w_prod;

   logic             s1_valid_q, s1_valid_d;
   logic             s1_user_q,  s1_user_d;
   logic             s1_last_q,  s1_last_d;
   logic [8:0][15:0] s1_prod_q,  s1_prod_d;

   logic             s2_valid_q, s2_valid_d;
   logic             s2_user_q,  s2_user_d;
   logic             s2_last_q,  s2_last_d;
   logic signed [17:0] s2_y_q,   s2_y_d;
   logic signed [17:0] s2_cb_q,  s2_cb_d;
   logic signed [17:0] s2_cr_q,  s2_cr_d;

   logic             m_valid_q,  m_valid_d;
   logic             m_user_q,   m_user_d;
   logic             m_last_q,   m_last_d;
   logic [23:0]      m_data_q,   m_data_d;

   logic signed [17:0] w_prod_s [9];
   logic signed [10:0] w_y_sh;
   logic signed [10:0] w_cb_sh;
   logic signed [10:0] w_cr_sh;

   function automatic logic [7:0] clamp8(input logic signed [10:0] v);
      if (v < 11'sd0) begin
         return 8'd0;
      end else if (v > 11'sd255) begin
         return 8'hFF;
      end else begin
         return v[7:0];
      end
   endfunction

   // The whole pipeline moves together; a stalled output freezes bubbles too
   assign w_en                = !m_valid_q || m_axis_video_tready;
   assign s_axis_video_tready = w_en;

   assign w_chan = {s_axis_video_tdata[7:0],
                    s_axis_video_tdata[15:8],
                    s_axis_video_tdata[23:16]};

   for (genvar gi = 0; gi < 9; gi++) begin : g_prod
      assign w_prod[gi]   = {8'd0, w_chan[gi % 3]} * {8'd0, c_coef[gi]};
      assign w_prod_s[gi] = $signed({2'b00, s1_prod_q[gi]});
   end

   // ---------------------------------------------------------------- S1
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_user_d  = s1_user_q;
      s1_last_d  = s1_last_q;
      s1_prod_d  = s1_prod_q;
      if (w_en) begin
         s1_valid_d = s_axis_video_tvalid;
         s1_user_d  = s_axis_video_tuser;
         s1_last_d  = s_axis_video_tlast;
         s1_prod_d  = w_prod;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid_q <= 1'b0;
         s1_user_q  <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_prod_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_user_q  <= s1_user_d;
         s1_last_q  <= s1_last_d;
         s1_prod_q  <= s1_prod_d;
      end
   end

   // ---------------------------------------------------------------- S2
   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_user_d  = s2_user_q;
      s2_last_d  = s2_last_q;
      s2_y_d     = s2_y_q;
      s2_cb_d    = s2_cb_q;
      s2_cr_d    = s2_cr_q;
      if (w_en) begin
         s2_valid_d = s1_valid_q;
         s2_user_d  = s1_user_q;
         s2_last_d  = s1_last_q;
         s2_y_d     = w_prod_s[0] + w_prod_s[1] + w_prod_s[2] + c_rnd;
         s2_cb_d    = w_prod_s[5] - w_prod_s[3] - w_prod_s[4] + c_rnd;
         s2_cr_d    = w_prod_s[6] - w_prod_s[7] - w_prod_s[8] + c_rnd;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s2_valid_q <= 1'b0;
         s2_user_q  <= 1'b0;
         s2_last_q  <= 1'b0;
         s2_y_q     <= '0;
         s2_cb_q    <= '0;
         s2_cr_q    <= '0;
      end else begin
         s2_valid_q <= s2_valid_d;
         s2_user_q  <= s2_user_d;
         s2_last_q  <= s2_last_d;
         s2_y_q     <= s2_y_d;
         s2_cb_q    <= s2_cb_d;
         s2_cr_q    <= s2_cr_d;
      end
   end

   // ---------------------------------------------------------------- S3
   // Taking bits [17:8] with sign extension is the floor (arithmetic) shift
   assign w_y_sh  = {s2_y_q[17],  s2_y_q[17:8]};
   assign w_cb_sh = {s2_cb_q[17], s2_cb_q[17:8]} + c_ofs;
   assign w_cr_sh = {s2_cr_q[17], s2_cr_q[17:8]} + c_ofs;

   always_comb begin
      m_valid_d = m_valid_q;
      m_user_d  = m_user_q;
      m_last_d  = m_last_q;
      m_data_d  = m_data_q;
      if (w_en) begin
         m_valid_d = s2_valid_q;
         m_user_d  = s2_user_q;
         m_last_d  = s2_last_q;
         m_data_d  = {clamp8(w_y_sh), clamp8(w_cb_sh), clamp8(w_cr_sh)};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_valid_q <= 1'b0;
         m_user_q  <= 1'b0;
         m_last_q  <= 1'b0;
         m_data_q  <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         m_user_q  <= m_user_d;
         m_last_q  <= m_last_d;
         m_data_q  <= m_data_d;
      end
   end

   assign m_axis_video_tdata  = m_data_q;
   assign m_axis_video_tvalid = m_valid_q;
   assign m_axis_video_tuser  = m_user_q;
   assign m_axis_video_tlast  = m_last_q;

endmodule
`default_nettype wire

// File: tb/tb_my_ycbcr.sv
`default_nettype none
// ============================================================================
// Module   : tb_my_ycbcr
// Purpose  : Directed, table-driven self-checking bench for my_ycbcr.
// Revision : 1.0  initial release
// ============================================================================
module tb_my_ycbcr;

   logic        clk = 1'b0;
   logic        rstn;
   logic [23:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic        s_user;
   logic        s_last;
   logic [23:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_user;
   logic        m_last;

   int tests = 0;
   int fails = 0;

   my_ycbcr dut (
      .clk                 (clk),
      .rstn                (rstn),
      .s_axis_video_tdata  (s_data),
      .s_axis_video_tvalid (s_valid),
      .s_axis_video_tready (s_ready),
      .s_axis_video_tuser  (s_user),
      .s_axis_video_tlast  (s_last),
      .m_axis_video_tdata  (m_data),
      .m_axis_video_tvalid (m_valid),
      .m_axis_video_tready (m_ready),
      .m_axis_video_tuser  (m_user),
      .m_axis_video_tlast  (m_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] rgb;
      logic [23:0] exp;
   } vec_t;

   task automatic chk24(input string name, input logic [23:0] act, input logic [23:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %06h expected %06h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] clampi(input int v);
      if (v < 0) return 8'd0;
      if (v > 255) return 8'hFF;
      return v[7:0];
   endfunction

   // Reference: BT.601 full range, floor division by 256 after +128 rounding
   function automatic logic [23:0] model(input logic [23:0] rgb);
      int r, g, b, y, cb, cr;
      r  = {24'd0, rgb[23:16]};
      g  = {24'd0, rgb[15:8]};
      b  = {24'd0, rgb[7:0]};
      y  = (77 * r + 150 * g + 29 * b + 128) >>> 8;
      cb = ((-43 * r - 85 * g + 128 * b + 128) >>> 8) + 128;
      cr = ((128 * r - 107 * g - 21 * b + 128) >>> 8) + 128;
      return {clampi(y), clampi(cb), clampi(cr)};
   endfunction

   function automatic logic [23:0] pat(input int n);
      logic [5:0] a, b, c;
      a = n[5:0];
      b = 6'(63 - n);
      c = 6'(n + 17);
      return {a, 2'b00, b, 2'b00, c, 2'b00};
   endfunction

   localparam int NV = 7;
   vec_t vecs [NV];

   initial begin
      logic [23:0] q[$];
      logic [23:0] held;
      logic        stalled;
      logic        in_acc;
      logic        inv [32];
      logic [23:0] ind [32];
      int          n;
      int          idx;
      logic        expv;

      vecs[0] = '{24'hFCFCFC, 24'hFC8080};
      vecs[1] = '{24'h000000, 24'h008080};
      vecs[2] = '{24'hFF0000, 24'h4D55FF};
      vecs[3] = '{24'h00FF00, 24'h952B15};
      vecs[4] = '{24'h0000FF, 24'h1DFF6B};
      vecs[5] = '{24'h808080, 24'h808080};
      vecs[6] = '{24'h102030, 24'h1D8B77};

      s_data  = '0;
      s_valid = 1'b0;
      s_user  = 1'b0;
      s_last  = 1'b0;
      m_ready = 1'b1;
      rstn    = 1'b1;
      #1 rstn = 1'b0;
      #1;
      chk1 ("reset_valid", m_valid, 1'b0);
      chk24("reset_data",  m_data,  24'h0);
      chk1 ("reset_user",  m_user,  1'b0);
      chk1 ("reset_last",  m_last,  1'b0);
      chk1 ("reset_ready", s_ready, 1'b1);
      tick();
      tick();
      #2 rstn = 1'b1;
      tick();

      // Streaming vectors: pixel driven before edge k is on the output after edge k+2
      for (int k = 0; k < NV + 3; k++) begin
         s_valid = (k < NV);
         s_data  = (k < NV) ? vecs[k].rgb : 24'h0;
         tick();
         idx  = k - 2;
         expv = (idx >= 0) && (idx < NV);
         chk1("stream_valid", m_valid, expv);
         if (expv) chk24("stream_data", m_data, vecs[idx].exp);
      end

      // Markers on a 4-pixel line
      for (int k = 0; k < 7; k++) begin
         s_valid = (k < 4);
         s_data  = vecs[k].rgb;
         s_user  = (k == 0);
         s_last  = (k == 3);
         tick();
         idx = k - 2;
         chk1("marker_valid", m_valid, (idx >= 0) && (idx <= 3));
         chk1("marker_user",  m_user,  idx == 0);
         chk1("marker_last",  m_last,  idx == 3);
      end
      s_user = 1'b0;
      s_last = 1'b0;

      // Bursty input: 4 valid, 3 idle
      n = 0;
      for (int k = 0; k < 24; k++) begin
         s_valid = (k < 21) && ((k % 7) < 4);
         s_data  = pat(n);
         if (s_valid) n++;
         inv[k] = s_valid;
         ind[k] = s_data;
         tick();
         idx  = k - 2;
         expv = (idx >= 0) ? inv[idx] : 1'b0;
         chk1("burst_valid", m_valid, expv);
         if (expv) chk24("burst_data", m_data, model(ind[idx]));
      end

      // Random back-pressure against a scoreboard, followed by a bounded drain
      n       = 0;
      stalled = 1'b0;
      held    = '0;
      for (int c = 0; c < 110; c++) begin
         if (c < 80) begin
            m_ready = 1'($urandom_range(0, 1));
            s_valid = ($urandom_range(0, 3) != 0);
         end else begin
            m_ready = 1'b1;
            s_valid = 1'b0;
         end
         s_data = pat(n);
         #1;
         chk1("bp_ready", s_ready, !(m_valid && !m_ready));
         if (stalled) begin
            chk1 ("bp_hold_valid", m_valid, 1'b1);
            chk24("bp_hold_data",  m_data,  held);
         end
         if (m_valid && m_ready) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL bp_extra: got %06h expected no output", m_data);
            end else begin
               chk24("bp_data", m_data, q.pop_front());
            end
         end
         stalled = m_valid && !m_ready;
         held    = m_data;
         in_acc  = s_valid && s_ready;
         @(posedge clk);
         #1;
         if (in_acc) begin
            q.push_back(model(s_data));
            n++;
         end
         if (c >= 80 && q.size() == 0 && !m_valid) break;
      end
      chk1("bp_drained",  q.size() == 0, 1'b1);
      chk1("bp_idle",     m_valid,       1'b0);
      chk1("bp_progress", n > 20,        1'b1);

      // Reset with three pixels in flight
      m_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         s_valid = 1'b1;
         s_data  = vecs[k + 2].rgb;
         s_user  = (k == 0);
         tick();
      end
      chk1 ("prerst_valid", m_valid, 1'b1);
      chk24("prerst_data",  m_data,  vecs[2].exp);
      chk1 ("prerst_user",  m_user,  1'b1);
      #2 rstn = 1'b0;
      #1;
      chk1 ("rst_valid", m_valid, 1'b0);
      chk24("rst_data",  m_data,  24'h0);
      chk1 ("rst_user",  m_user,  1'b0);
      chk1 ("rst_last",  m_last,  1'b0);
      chk1 ("rst_ready", s_ready, 1'b1);
      s_valid = 1'b0;
      s_user  = 1'b0;
      tick();
      #2 rstn = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk1("postrst_valid", m_valid, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
